// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants, types and helpers for the seven-segment scan controller
package ssd_pkg;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam int NUM_DIG = 4;
  localparam int DEF_DIV_MAX = 100000;
  localparam int DEF_BLANK_CYC = 1000;
  typedef logic [1:0] dig_sel_t;
  // digit s is a leading zero when it and every digit above it are zero; digit 0 never is
  function automatic logic lead_zero(input logic [15:0] v, input dig_sel_t s);
    lead_zero = s != 2'd0;
    for (int i = 0; i < NUM_DIG; i++)
      if (i >= int'(s) && v[4*i +: 4] != 4'h0) lead_zero = 1'b0;
  endfunction
endpackage

// File: rtl/ssd_scan_prescaler.sv
// ssd_scan_prescaler: slot counter and digit selector for the display scan
module ssd_scan_prescaler
  import ssd_pkg::*;
#(
  parameter int DIV_MAX = DEF_DIV_MAX,
  parameter int DIV_W = 17,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic     clk,
  input  logic     rst_n,
  output dig_sel_t sel,
  output logic     slot_wrap,
  output logic     in_blank,
  output logic     frame_end
);
  logic [DIV_W-1:0] cnt;
  assign slot_wrap = cnt == DIV_W'(DIV_MAX - 1);
  assign in_blank = cnt < DIV_W'(BLANK_CYC);
  assign frame_end = slot_wrap && sel == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sel <= '0;
    end else begin
      cnt <= slot_wrap ? '0 : cnt + 1'b1;
      if (slot_wrap) sel <= sel + 1'b1;
    end
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: 4-digit common-anode scan with blanking, leading-zero suppression and frame-synchronous update
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int DIV_MAX = DEF_DIV_MAX,
  parameter int DIV_W = 17,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dig_en,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [3:0]  nib,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick
);
  dig_sel_t    sel;
  logic        slot_wrap, in_blank, frame_end, drive, pending;
  logic [15:0] active, shadow;
  logic [3:0]  active_dp, shadow_dp;
  ssd_scan_prescaler #(.DIV_MAX(DIV_MAX), .DIV_W(DIV_W), .BLANK_CYC(BLANK_CYC)) u_pre (
    .clk(clk), .rst_n(rst_n), .sel(sel), .slot_wrap(slot_wrap), .in_blank(in_blank), .frame_end(frame_end)
  );
  assign drive = !in_blank && dig_en[sel] && !(lz_blank && lead_zero(active, sel));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active <= '0;
      shadow <= '0;
      active_dp <= '0;
      shadow_dp <= '0;
      pending <= 1'b0;
      nib <= '0;
      an <= AN_OFF;
      dp <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (load) begin
        shadow <= value;
        shadow_dp <= dp_in;
      end
      // a load on the boundary cycle bypasses the shadow so it is never a frame late
      if (frame_end) begin
        active <= load ? value : pending ? shadow : active;
        active_dp <= load ? dp_in : pending ? shadow_dp : active_dp;
        pending <= 1'b0;
      end else if (load) pending <= 1'b1;
      nib <= active[{sel, 2'b00} +: 4];
      an <= drive ? ~(4'b0001 << sel) : AN_OFF;
      dp <= drive ? ~active_dp[sel] : 1'b1;
      frame_tick <= slot_wrap && frame_end;
    end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: directed table-driven bench for the scan controller with a short slot
module tb_ssd_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz_blank = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dig_en = 4'hF, dp_in = '0;
  logic [3:0]  nib, an;
  logic        dp, frame_tick;
  int total = 0, bad = 0, cyc = 0;

  ssd_scan_ctrl #(.DIV_MAX(8), .DIV_W(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dig_en(dig_en), .dp_in(dp_in),
    .lz_blank(lz_blank), .nib(nib), .an(an), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        dp;
    logic        ft;
    logic        ld;
    logic [15:0] v;
    logic [3:0]  dpi;
    logic        lz;
    logic [3:0]  en;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic adv(input int k);
    if (cyc < k) begin
      while (cyc < k) begin
        @(posedge clk);
        cyc++;
        #1 load = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [3:0] e_nib, input logic e_dp, input logic e_ft);
    chk({tag, ".an"}, 32'(an), 32'(e_an));
    chk({tag, ".nib"}, 32'(nib), 32'(e_nib));
    chk({tag, ".dp"}, 32'(dp), 32'(e_dp));
    chk({tag, ".ft"}, 32'(frame_tick), 32'(e_ft));
  endtask

  initial begin
    // k = clock edges since reset release; outputs reflect the cnt/sel state of edge k-1
    vq.push_back('{0,   4'hF, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{1,   4'hF, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{2,   4'hF, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{3,   4'hE, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{4,   4'hE, 4'h0, 1, 0, 1, 16'h1234, 4'h4, 0, 4'hF});
    vq.push_back('{8,   4'hE, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{9,   4'hF, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{11,  4'hD, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{27,  4'h7, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{31,  4'h7, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{32,  4'h7, 4'h0, 1, 1, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{33,  4'hF, 4'h4, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{35,  4'hE, 4'h4, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{36,  4'hE, 4'h4, 1, 0, 1, 16'hABCD, 4'h1, 0, 4'hF});
    vq.push_back('{43,  4'hD, 4'h3, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{51,  4'hB, 4'h2, 0, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{59,  4'h7, 4'h1, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{64,  4'h7, 4'h1, 1, 1, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{67,  4'hE, 4'hD, 0, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{75,  4'hD, 4'hC, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{83,  4'hB, 4'hB, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{91,  4'h7, 4'hA, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{95,  4'h7, 4'hA, 1, 0, 1, 16'h0050, 4'h0, 0, 4'hF});
    vq.push_back('{96,  4'h7, 4'hA, 1, 1, 0, 16'h0000, 4'h0, 0, 4'hF});
    vq.push_back('{99,  4'hE, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{107, 4'hD, 4'h5, 1, 0, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{115, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{123, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{128, 4'hF, 4'h0, 1, 1, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{131, 4'hE, 4'h0, 1, 0, 1, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{139, 4'hD, 4'h5, 1, 0, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{163, 4'hE, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{171, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{179, 4'hF, 4'h0, 1, 0, 0, 16'h0000, 4'h0, 1, 4'hF});
    vq.push_back('{187, 4'hF, 4'h0, 1, 0, 1, 16'h1234, 4'hF, 0, 4'hA});
    vq.push_back('{195, 4'hF, 4'h4, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hA});
    vq.push_back('{203, 4'hD, 4'h3, 0, 0, 0, 16'h0000, 4'h0, 0, 4'hA});
    vq.push_back('{211, 4'hF, 4'h2, 1, 0, 0, 16'h0000, 4'h0, 0, 4'hA});
    vq.push_back('{219, 4'h7, 4'h1, 0, 0, 0, 16'h0000, 4'h0, 0, 4'hA});

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    foreach (vq[i]) begin
      adv(vq[i].k);
      chk_out($sformatf("v%0d", i), vq[i].an, vq[i].nib, vq[i].dp, vq[i].ft);
      if (vq[i].k == 96) chk("pending_clear", 32'(dut.pending), 32'd0);
      lz_blank = vq[i].lz;
      dig_en = vq[i].en;
      if (vq[i].ld) begin
        value = vq[i].v;
        dp_in = vq[i].dpi;
        load = 1'b1;
      end
    end

    dig_en = 4'hF;
    adv(243);
    chk_out("pre_rst", 4'hB, 4'h2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 4'hF, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    adv(2);
    chk_out("rst_blank", 4'hF, 4'h0, 1'b1, 1'b0);
    adv(3);
    chk_out("rst_dig0", 4'hE, 4'h0, 1'b1, 1'b0);
    adv(11);
    chk_out("rst_dig1", 4'hD, 4'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
